register_file_scoreboarded: RTL and testbench
=============================================

Name: register_file_scoreboarded

Overview:
Parametrised multi-read-port register file with optional write-through bypass, a program-counter alias register and a per-register busy scoreboard for outstanding long-latency writes, such as loads.
Sits in the decode stage of the core. Read ports feed operand muxes, and the single write port is driven from writeback.
The scoreboard lets the hazard unit stall on operands whose producer has not yet written back.

Parameters:
num_bits, 32, data width of each register and of program_counter
address_bits, 4, register index width; num_registers = 2**address_bits
num_read_ports, 3, number of independent combinational read ports (1..4)
write_through, 1, 1 = a same-cycle write is visible on the read ports; 0 = the old value is read until the next edge

Ports:
clock  in  1  single core clock; all state updates on posedge
reset  in  1  synchronous, active-high; clears all registers and the scoreboard
write_enable  in  1  commit write_data to write_address at the next posedge
write_address  in  address_bits  destination register for the write
write_data  in  num_bits  value to write
program_counter  in  num_bits  value returned when reading the alias index (the datapath supplies PC+8)
read_address  in  num_read_ports*address_bits  packed; port i occupies bits [i*address_bits +: address_bits]
read_data  out  num_read_ports*num_bits  packed; port i occupies bits [i*num_bits +: num_bits]
read_busy  out  num_read_ports  bit i = register addressed by port i is reserved (pending)
reserve_enable  in  1  mark reserve_address busy at the next posedge
reserve_address  in  address_bits  register to reserve
busy_count  out  address_bits+1  number of currently reserved registers

Behaviour:
- Alias index: pc_index = num_registers-1. Reads of pc_index return program_counter combinationally. Writes and reservations to pc_index are silently dropped; its busy bit is always 0.
- Storage: num_registers-1 physical registers of num_bits. On posedge with reset=1, all are cleared to 0, all busy bits to 0 and busy_count to 0. reset takes priority over every other input in that cycle.
- Write: on posedge with write_enable=1 and write_address != pc_index, the register takes write_data. Latency is 1 cycle to storage.
- Reads: combinational, no latency. Ports are independent; any number of ports may address the same register.
- Bypass, write_through=1: if write_enable=1 and read_address[i]==write_address != pc_index, read_data[i] = write_data in the same cycle. With write_through=0 the port shows the stored value.
- Scoreboard per register, updated on posedge:
  - reserve_enable only → busy set.
  - write_enable only → busy cleared.
  - Both to the same address → busy stays set (the new reservation wins; the write still updates storage).
  - Both to different addresses → each applied independently.
- read_busy[i] = busy[read_address[i]] from registered state. Bypass does not clear read_busy in the write cycle; it drops on the following cycle.
- busy_count is registered and tracks the popcount of the busy bits exactly:
  - +1 only on a 0→1 transition.
  - −1 only on a 1→0 transition.
  - A set and a clear on different registers in the same edge leave it unchanged.
  - Reserving an already-busy register, or writing a non-busy register, leaves it unchanged.
  - Maximum value is num_registers-1; no wrap is possible.
- Reset mid-operation: every pending reservation is discarded. No writes issued in the reset cycle take effect.

Decomposition:
- Package register_file_pkg holds:
  - default parameter constants;
  - function pc_index(address_bits);
  - typedef for a packed read-port bundle.
- Sub-module register_scoreboard (busy bit vector, set/clear priority, busy_count) is natural and is verified standalone.
- Storage uses resettable_flop_enabled instances per register, with enabled = write_enable && decoded address match.

Test Plan:
- Reset, then read every index with program_counter=0x0000_1008 → all ports return 0 for indices 0..14 and 0x0000_1008 for index 15; busy_count=0.
- Write 0xDEAD_BEEF to r3 and read r3 on ports 0 and 2 in the same cycle → bypass returns 0xDEAD_BEEF immediately with write_through=1. With write_through=0 the ports return 0, then 0xDEAD_BEEF next cycle.
- Reserve r5, then next cycle reserve r5 again → read_busy=1 and busy_count=1 throughout. Write r5=7 → busy drops the cycle after the write and busy_count=0.
- Same edge: reserve r2 and write r2=0x55 → storage r2=0x55, busy stays 1, busy_count=1.
- Same edge: reserve r4 and write r6 while r6 is busy → r4 busy, r6 clear, busy_count unchanged.
- Write 0x1234 to r15 and reserve r15 → reads of r15 still return program_counter, read_busy=0, busy_count unchanged.
- Reserve r1 and r2, assert reset with write_enable=1 to r1 → all busy bits clear, busy_count=0, r1 reads 0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// The highest register index is an alias for the program counter.
package register_file_pkg;

  localparam int DEFAULT_NUM_BITS       = 32;
  localparam int DEFAULT_ADDRESS_BITS   = 4;
  localparam int DEFAULT_NUM_READ_PORTS = 3;
  localparam bit DEFAULT_WRITE_THROUGH  = 1'b1;

  function automatic int pc_index(input int address_bits);
    return (1 << address_bits) - 1;
  endfunction

  typedef struct packed {
    logic [DEFAULT_ADDRESS_BITS-1:0] address;
    logic [DEFAULT_NUM_BITS-1:0]     data;
    logic                            busy;
  } read_port_t;

endpackage

// File: rtl/register_scoreboard.sv
// Busy bit per register for outstanding long-latency writes, plus a running
// count of reserved registers. A reservation beats a clear to the same register.
module register_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    set_enable,
  input  logic [ADDRESS_BITS-1:0] set_address,
  input  logic                    clear_enable,
  input  logic [ADDRESS_BITS-1:0] clear_address,
  output logic [(1<<ADDRESS_BITS)-1:0] busy,
  output logic [ADDRESS_BITS:0]   busy_count
);

  localparam int NUM_REGISTERS = 1 << ADDRESS_BITS;
  localparam logic [ADDRESS_BITS-1:0] PC_ADDR = ADDRESS_BITS'(pc_index(ADDRESS_BITS));
  localparam logic [ADDRESS_BITS:0]   COUNT_ONE = 1;

  logic [NUM_REGISTERS-1:0] busy_q, busy_d;
  logic [ADDRESS_BITS:0]    count_q, count_d;
  logic                     set_valid, clear_valid, rise, fall;

  always_comb begin
    set_valid   = set_enable && (set_address != PC_ADDR);
    clear_valid = clear_enable && (clear_address != PC_ADDR);
    // Only real 0->1 and 1->0 transitions move the count.
    rise = set_valid && !busy_q[set_address];
    fall = clear_valid && busy_q[clear_address] &&
           !(set_valid && (set_address == clear_address));
    busy_d = busy_q;
    if (clear_valid) busy_d[clear_address] = 1'b0;
    if (set_valid)   busy_d[set_address]   = 1'b1;
    count_d = count_q;
    if (rise && !fall)      count_d = count_q + COUNT_ONE;
    else if (fall && !rise) count_d = count_q - COUNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/resettable_flop_enabled.sv
// Single storage register with synchronous clear and load enable.
module resettable_flop_enabled #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (enable) data_d = d;
  end

  always_ff @(posedge clock) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/register_file_scoreboarded.sv
// Multi-port register file with PC alias, optional write-through bypass
// and a busy scoreboard for the hazard unit.
module register_file_scoreboarded
  import register_file_pkg::*;
#(
  parameter int num_bits       = DEFAULT_NUM_BITS,
  parameter int address_bits   = DEFAULT_ADDRESS_BITS,
  parameter int num_read_ports = DEFAULT_NUM_READ_PORTS,
  parameter bit write_through  = DEFAULT_WRITE_THROUGH
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   write_enable,
  input  logic [address_bits-1:0]                write_address,
  input  logic [num_bits-1:0]                    write_data,
  input  logic [num_bits-1:0]                    program_counter,
  input  logic [num_read_ports*address_bits-1:0] read_address,
  output logic [num_read_ports*num_bits-1:0]     read_data,
  output logic [num_read_ports-1:0]              read_busy,
  input  logic                                   reserve_enable,
  input  logic [address_bits-1:0]                reserve_address,
  output logic [address_bits:0]                  busy_count
);

  localparam int NUM_REGISTERS = 1 << address_bits;
  localparam logic [address_bits-1:0] PC_ADDR = address_bits'(pc_index(address_bits));

  logic [num_bits-1:0]      storage [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] busy;
  logic [address_bits-1:0]  port_address;

  for (genvar r = 0; r < NUM_REGISTERS - 1; r++) begin : g_reg
    resettable_flop_enabled #(.WIDTH(num_bits)) u_flop (
      .clock  (clock),
      .reset  (reset),
      .enable (write_enable && (write_address == address_bits'(r))),
      .d      (write_data),
      .q      (storage[r])
    );
  end
  // The alias slot has no storage; reads of it are redirected to the PC.
  assign storage[NUM_REGISTERS-1] = '0;

  register_scoreboard #(.ADDRESS_BITS(address_bits)) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .set_enable    (reserve_enable),
    .set_address   (reserve_address),
    .clear_enable  (write_enable),
    .clear_address (write_address),
    .busy          (busy),
    .busy_count    (busy_count)
  );

  always_comb begin
    read_data    = '0;
    read_busy    = '0;
    port_address = '0;
    for (int i = 0; i < num_read_ports; i++) begin
      port_address = read_address[i*address_bits +: address_bits];
      if (port_address == PC_ADDR)
        read_data[i*num_bits +: num_bits] = program_counter;
      else if (write_through && write_enable && (write_address == port_address))
        read_data[i*num_bits +: num_bits] = write_data;
      else
        read_data[i*num_bits +: num_bits] = storage[port_address];
      read_busy[i] = busy[port_address];
    end
  end

endmodule

// File: tb/tb_register_file_scoreboarded.sv
// Bench for register_file_scoreboarded: directed vector table, then model-driven
// sweep and random traffic, checked against write-through and registered-read instances.
module tb_register_file_scoreboarded;
  import register_file_pkg::*;

  localparam int NB = 32;
  localparam int AB = 4;
  localparam int NP = 3;
  localparam int EW = 2*NP*NB + NP + AB + 1;
  localparam logic [31:0] P  = 32'h0000_1008;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  logic             clock = 1'b0;
  logic             reset, write_enable, reserve_enable;
  logic [AB-1:0]    write_address, reserve_address;
  logic [NB-1:0]    write_data, program_counter;
  logic [NP*AB-1:0] read_address;
  logic [NP*NB-1:0] rd_wt, rd_nwt;
  logic [NP-1:0]    busy_wt, busy_nwt;
  logic [AB:0]      cnt_wt, cnt_nwt;

  int pass_count  = 0;
  int total_count = 0;

  logic [EW-1:0] exp_q[$];

  logic [NB-1:0] mem   [16];
  logic          mbusy [16];
  logic [AB:0]   mcnt;

  always #5 clock = ~clock;

  register_file_scoreboarded #(.num_bits(NB), .address_bits(AB), .num_read_ports(NP),
                               .write_through(1'b1)) dut (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .program_counter(program_counter), .read_address(read_address),
    .read_data(rd_wt), .read_busy(busy_wt), .reserve_enable(reserve_enable),
    .reserve_address(reserve_address), .busy_count(cnt_wt));

  register_file_scoreboarded #(.num_bits(NB), .address_bits(AB), .num_read_ports(NP),
                               .write_through(1'b0)) dut_nwt (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .program_counter(program_counter), .read_address(read_address),
    .read_data(rd_nwt), .read_busy(busy_nwt), .reserve_enable(reserve_enable),
    .reserve_address(reserve_address), .busy_count(cnt_nwt));

  typedef struct {
    logic          rst, we, re;
    logic [AB-1:0] wa, ra;
    logic [NB-1:0] wd, pc;
    logic [NP*AB-1:0] rda;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic rst, we, input int wa, input logic [31:0] wd,
                            input logic re, input int ra, input int a0, a1, a2,
                            input logic [31:0] pc, w0, w1, w2, n0, n1, n2,
                            input logic [2:0] b, input int cnt);
    vec_t t;
    t.rst = rst; t.we = we; t.wa = AB'(wa); t.wd = wd; t.re = re; t.ra = AB'(ra);
    t.rda = {AB'(a2), AB'(a1), AB'(a0)};
    t.pc  = pc;
    t.exp = {w2, w1, w0, n2, n1, n0, b, (AB+1)'(cnt)};
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s got=%h expected=%h", name, got, exp);
  endtask

  task automatic run_cycle(input logic rst, we, input logic [AB-1:0] wa,
                           input logic [NB-1:0] wd, input logic re,
                           input logic [AB-1:0] ra, input logic [NP*AB-1:0] rda,
                           input logic [NB-1:0] pc, input logic [EW-1:0] exp);
    logic [EW-1:0] e;
    @(negedge clock);
    reset = rst; write_enable = we; write_address = wa; write_data = wd;
    reserve_enable = re; reserve_address = ra; read_address = rda;
    program_counter = pc;
    exp_q.push_back(exp);
    #4;
    e = exp_q.pop_front();
    chk("read_data_wt",   128'(rd_wt),    128'(e[EW-1 -: NP*NB]));
    chk("read_data_nwt",  128'(rd_nwt),   128'(e[EW-NP*NB-1 -: NP*NB]));
    chk("read_busy_wt",   128'(busy_wt),  128'(e[AB+NP -: NP]));
    chk("read_busy_nwt",  128'(busy_nwt), 128'(e[AB+NP -: NP]));
    chk("busy_count_wt",  128'(cnt_wt),   128'(e[AB:0]));
    chk("busy_count_nwt", 128'(cnt_nwt),  128'(e[AB:0]));
  endtask

  // Reference model: expected outputs from model state, then advance the model.
  task automatic model_step(input logic rst, we, input logic [AB-1:0] wa,
                            input logic [NB-1:0] wd, input logic re,
                            input logic [AB-1:0] ra, input logic [NP*AB-1:0] rda,
                            input logic [NB-1:0] pc);
    logic [NP*NB-1:0] ew, en;
    logic [NP-1:0]    eb;
    logic [AB-1:0]    a;
    logic [NB-1:0]    d;
    for (int p = 0; p < NP; p++) begin
      a = rda[p*AB +: AB];
      d = (a == 4'd15) ? pc : mem[a];
      en[p*NB +: NB] = d;
      ew[p*NB +: NB] = (we && wa == a && a != 4'd15) ? wd : d;
      eb[p] = (a == 4'd15) ? 1'b0 : mbusy[a];
    end
    run_cycle(rst, we, wa, wd, re, ra, rda, pc, {ew, en, eb, mcnt});
    if (rst) begin
      for (int r = 0; r < 16; r++) begin mem[r] = '0; mbusy[r] = 1'b0; end
    end else begin
      if (we && wa != 4'd15) begin mem[wa] = wd; mbusy[wa] = 1'b0; end
      if (re && ra != 4'd15) mbusy[ra] = 1'b1;
    end
    mcnt = '0;
    for (int r = 0; r < 16; r++) if (mbusy[r]) mcnt = mcnt + 1'b1;
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; write_address = '0; write_data = '0;
    reserve_enable = 1'b0; reserve_address = '0; read_address = '0; program_counter = P;

    //  rst we wa wd            re ra  a0 a1 a2  pc            w0 w1 w2         n0 n1 n2         busy    cnt
    v(0,0, 0,0,            0, 0,  0, 1, 2, P,            0, 0, 0,         0, 0, 0,         3'b000, 0);
    v(0,0, 0,0,            0, 0,  3, 4, 5, P,            0, 0, 0,         0, 0, 0,         3'b000, 0);
    v(0,0, 0,0,            0, 0,  6, 7, 8, P,            0, 0, 0,         0, 0, 0,         3'b000, 0);
    v(0,0, 0,0,            0, 0,  9,10,11, P,            0, 0, 0,         0, 0, 0,         3'b000, 0);
    v(0,0, 0,0,            0, 0, 12,13,14, P,            0, 0, 0,         0, 0, 0,         3'b000, 0);
    v(0,0, 0,0,            0, 0, 15,15, 0, P,            P, P, 0,         P, P, 0,         3'b000, 0);
    v(0,1, 3,DB,           0, 0,  3, 0, 3, P,            DB,0, DB,        0, 0, 0,         3'b000, 0);
    v(0,0, 0,0,            0, 0,  3, 0, 3, P,            DB,0, DB,        DB,0, DB,        3'b000, 0);
    v(0,0, 0,0,            1, 5,  5, 5, 5, P,            0, 0, 0,         0, 0, 0,         3'b000, 0);
    v(0,0, 0,0,            1, 5,  5, 5, 5, P,            0, 0, 0,         0, 0, 0,         3'b111, 1);
    v(0,1, 5,7,            0, 0,  5, 3, 5, P,            7, DB,7,         0, DB,0,         3'b101, 1);
    v(0,0, 0,0,            0, 0,  5, 5, 5, P,            7, 7, 7,         7, 7, 7,         3'b000, 0);
    v(0,1, 2,32'h55,       1, 2,  2, 2, 5, P,            32'h55,32'h55,7, 0, 0, 7,         3'b000, 0);
    v(0,0, 0,0,            0, 0,  2, 5, 2, P,            32'h55,7,32'h55, 32'h55,7,32'h55, 3'b101, 1);
    v(0,0, 0,0,            1, 6,  6, 4, 2, P,            0, 0, 32'h55,    0, 0, 32'h55,    3'b100, 1);
    v(0,1, 6,32'h66,       1, 4,  6, 4, 2, P,            32'h66,0,32'h55, 0, 0, 32'h55,    3'b101, 2);
    v(0,0, 0,0,            0, 0,  4, 6, 2, P,            0,32'h66,32'h55, 0,32'h66,32'h55, 3'b101, 2);
    v(0,1,15,32'h1234,     1,15, 15,15, 4, P,            P, P, 0,         P, P, 0,         3'b100, 2);
    v(0,1, 3,32'h33,       0, 0, 15, 2, 4, 32'h2222,     32'h2222,32'h55,0, 32'h2222,32'h55,0, 3'b110, 2);
    v(0,0, 0,0,            1, 1,  3,15, 1, 32'h2222,     32'h33,32'h2222,0, 32'h33,32'h2222,0, 3'b000, 2);
    v(1,1, 1,32'hAAAA,     1, 7,  2, 4,15, 32'h2222,     32'h55,0,32'h2222, 32'h55,0,32'h2222, 3'b011, 3);
    v(0,0, 0,0,            0, 0,  1, 2, 4, 32'h2222,     0, 0, 0,         0, 0, 0,         3'b000, 0);
    v(0,0, 0,0,            0, 0,  3, 5, 6, 32'h2222,     0, 0, 0,         0, 0, 0,         3'b000, 0);

    repeat (2) @(negedge clock);
    for (int i = 0; i < vecs.size(); i++)
      run_cycle(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re,
                vecs[i].ra, vecs[i].rda, vecs[i].pc, vecs[i].exp);

    // Model starts from the post-reset state reached by the table.
    for (int r = 0; r < 16; r++) begin mem[r] = '0; mbusy[r] = 1'b0; end
    mcnt = '0;

    // Reserve every index, including the alias, to reach the maximum count.
    for (int i = 0; i < 16; i++)
      model_step(0, 0, '0, '0, 1, AB'(i), {AB'(i), AB'(15 - i), AB'(i)}, $urandom);
    model_step(0, 0, '0, '0, 0, '0, {4'd1, 4'd14, 4'd15}, P);
    // Release them one by one with writes.
    for (int i = 0; i < 16; i++)
      model_step(0, 1, AB'(i), $urandom, 0, '0, {AB'(i), AB'(i + 1), AB'(i)}, P);

    for (int n = 0; n < 300; n++)
      model_step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                 AB'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 1) == 1, AB'($urandom_range(0, 15)),
                 NP*AB'($urandom), $urandom);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
